timer_irq_src: RTL and testbench
================================

Name: timer_irq_src

Overview:
- Memory-mapped countdown timer on the CPU bridge.
- Produces the hardware interrupt line that drives one bit of the coprocessor-0 HWInt[5:0] input.
- Software programs it through sw/lw word accesses and acknowledges the interrupt by rewriting CTRL or PRESET.
- Acts as the interrupt source (initiator) side of the HWInt/IntReq path.

Parameters:
- RESET_PRESET, 32'd0, value PRESET takes on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- Addr  input  2  word offset in the timer window (byte address [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- We  input  1  bus write enable, sampled on the rising edge of clk.
- DIn  input  32  bus write data.
- DOut  output  32  combinational read data for Addr.
- IRQ  output  1  interrupt request to CP0 HWInt bit (level).

Behaviour:
- Reset (async, high) values:
  - CTRL=0, PRESET=RESET_PRESET, COUNT=0.
  - state=IDLE, irq_flag=0.
  - Outputs: IRQ=0; DOut follows Addr with reset contents.
- CTRL fields:
  - [0] EN: count enable.
  - [2:1] MODE: 0 = one-shot, 1 = auto-reload, 2/3 behave as 0.
  - [3] IM: interrupt mask, 1 = IRQ allowed.
  - [31:4] read 0.
- Writes (We=1, registered on clk edge):
  - Addr0: CTRL[3:0]<=DIn[3:0].
  - Addr1: PRESET<=DIn.
  - Addr2 and Addr3: writes ignored.
  - Any write to Addr0 or Addr1 clears irq_flag (software acknowledge).
- Reads, combinational:
  - Addr0 = {28'b0, CTRL[3:0]}.
  - Addr1 = PRESET.
  - Addr2 = COUNT.
  - Addr3 = 0.
- IRQ = irq_flag & CTRL.IM, purely combinational, no extra latency.
- FSM (state register, 2 bits):
  - IDLE: EN=1 -> LOAD; else stay.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT, by priority:
    - EN=0 -> IDLE, COUNT holds.
    - COUNT>1 -> COUNT<=COUNT-1.
    - Otherwise COUNT<=0, irq_flag<=1, -> INT.
  - INT:
    - MODE=1: irq_flag<=0, -> LOAD.
    - Otherwise: CTRL.EN<=0, -> IDLE, irq_flag held.
- Timing:
  - EN written at edge e0 with PRESET=N≥1: LOAD at e1, COUNT=N at e2, irq_flag=1 after edge e2+N (IRQ high N+2 edges after the write).
  - PRESET=0 behaves as PRESET=1.
- Auto-reload: irq_flag is a 1-cycle pulse; period N+2 cycles.
- One-shot: irq_flag stays set until a CTRL/PRESET write; COUNT stays 0.
- Simultaneous events:
  - Bus write to CTRL in the same cycle the FSM clears EN (INT, one-shot): bus write wins for all CTRL bits.
  - Write clearing irq_flag in the same cycle the FSM sets it: set wins.
  - Write to PRESET during CNT: no effect on COUNT until the next LOAD.
  - Write EN=0 during LOAD: LOAD completes, then CNT sees EN=0 -> IDLE.
- Async reset mid-count: state returns to IDLE and IRQ drops in the same cycle, no clock needed.
- COUNT never wraps: decrement never occurs from 0.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - CTRL[7:4] = PSC is writable and readable.
  - An internal 4-bit tick counter is cleared in LOAD and on each decrement.
  - In CNT, the decrement/terminal check happens only when the tick counter equals PSC; otherwise the tick counter increments.
  - IRQ latency becomes N*(PSC+1)+2 edges.
  - EN=0 in CNT still exits immediately.
- Undefined:
  - CTRL[7:4] reads 0 and writes to it are ignored.
  - No tick counter exists; a decrement is attempted every CNT cycle.

Test Plan:
- Reset/readback: assert reset mid-clock with IRQ high -> IRQ=0 immediately; reads return CTRL=0, PRESET=RESET_PRESET, COUNT=0.
- One-shot: PRESET=5, CTRL=4'b1001 -> IRQ rises exactly 7 edges after the CTRL write, stays high; CTRL reads 8 (EN cleared); writing CTRL=8 drops IRQ next edge.
- Auto-reload: PRESET=3, CTRL=4'b1011 -> IRQ 1-cycle pulses every 5 cycles, at least 4 periods; COUNT sequence 3,2,1,0.
- Mask: PRESET=2, CTRL=4'b0001 -> IRQ stays 0; after expiry, write CTRL=4'b1000 -> IRQ 0, because the write acknowledged the flag.
- Pause/edge: PRESET=10, enable, clear EN when COUNT=6 -> COUNT holds 6, no IRQ; write PRESET=0, enable -> IRQ 3 edges later; write to Addr2 leaves COUNT unchanged.
- Prescale (TIMER_PRESCALE_EN): PRESET=4, CTRL=32'h39 (PSC=3, IM=1, one-shot) -> IRQ 18 edges after the write.

Source files
------------

// File: rtl/timer_irq_src.sv
// rtl/timer_irq_src.sv - memory-mapped countdown timer driving one CP0 HWInt line (optional prescaler: TIMER_PRESCALE_EN)
module timer_irq_src #(
    parameter logic [31:0] RESET_PRESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_nx;
    logic        irq_flag;

    logic        irq_set;
    logic        irq_clr_fsm;
    logic        en_clr;
    logic        step_ok;

    logic        wr_ctrl;
    logic        wr_preset;
    logic [31:0] ctrl_rd;

`ifdef TIMER_PRESCALE_EN
    logic [3:0]  ctrl_psc;
    logic [3:0]  tick;
    logic [3:0]  tick_nx;

    // The countdown only advances once the tick counter has reached PSC.
    assign step_ok = (tick == ctrl_psc);
    assign ctrl_rd = {24'b0, ctrl_psc, ctrl_im, ctrl_mode, ctrl_en};
`else
    assign step_ok = 1'b1;
    assign ctrl_rd = {28'b0, ctrl_im, ctrl_mode, ctrl_en};
`endif

    assign wr_ctrl   = We && (Addr == 2'd0);
    assign wr_preset = We && (Addr == 2'd1);

    // Next-state and datapath decisions of the countdown FSM.
    always_comb begin
        state_nx    = state;
        count_nx    = count;
        irq_set     = 1'b0;
        irq_clr_fsm = 1'b0;
        en_clr      = 1'b0;
`ifdef TIMER_PRESCALE_EN
        tick_nx     = tick;
`endif
        case (state)
            IDLE: begin
                if (ctrl_en) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                count_nx = preset;
`ifdef TIMER_PRESCALE_EN
                tick_nx  = 4'd0;
`endif
                state_nx = CNT;
            end
            CNT: begin
                if (!ctrl_en) begin
                    state_nx = IDLE;
                end else if (!step_ok) begin
`ifdef TIMER_PRESCALE_EN
                    tick_nx = tick + 4'd1;
`endif
                end else begin
`ifdef TIMER_PRESCALE_EN
                    tick_nx = 4'd0;
`endif
                    // Terminal at 1 (not 0) so PRESET=0 behaves as 1 and COUNT never wraps.
                    if (count > 32'd1) begin
                        count_nx = count - 32'd1;
                    end else begin
                        count_nx = 32'd0;
                        irq_set  = 1'b1;
                        state_nx = INT;
                    end
                end
            end
            INT: begin
                if (ctrl_mode == 2'd1) begin
                    irq_clr_fsm = 1'b1;
                    state_nx    = LOAD;
                end else begin
                    en_clr   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state, count and prescale tick registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 32'd0;
`ifdef TIMER_PRESCALE_EN
            tick  <= 4'd0;
`endif
        end else begin
            state <= state_nx;
            count <= count_nx;
`ifdef TIMER_PRESCALE_EN
            tick  <= tick_nx;
`endif
        end
    end

    // CTRL register: a bus write overrides the FSM's one-shot EN clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'd0;
            ctrl_im   <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            ctrl_psc  <= 4'd0;
`endif
        end else if (wr_ctrl) begin
            ctrl_en   <= DIn[0];
            ctrl_mode <= DIn[2:1];
            ctrl_im   <= DIn[3];
`ifdef TIMER_PRESCALE_EN
            ctrl_psc  <= DIn[7:4];
`endif
        end else if (en_clr) begin
            ctrl_en   <= 1'b0;
        end
    end

    // PRESET register; only reaches COUNT on the next LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preset <= RESET_PRESET;
        end else if (wr_preset) begin
            preset <= DIn;
        end
    end

    // Interrupt flag: expiry set beats a same-cycle software acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_flag <= 1'b0;
        end else if (irq_set) begin
            irq_flag <= 1'b1;
        end else if (wr_ctrl || wr_preset || irq_clr_fsm) begin
            irq_flag <= 1'b0;
        end
    end

    // Combinational register read mux.
    always_comb begin
        DOut = 32'd0;
        case (Addr)
            2'd0:    DOut = ctrl_rd;
            2'd1:    DOut = preset;
            2'd2:    DOut = count;
            default: DOut = 32'd0;
        endcase
    end

    assign IRQ = irq_flag & ctrl_im;

endmodule

// File: tb/tb_timer_irq_src.sv
// tb/tb_timer_irq_src.sv - scoreboard testbench for timer_irq_src
module tb_timer_irq_src;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    timer_irq_src #(.RESET_PRESET(32'd7)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .We    (We),
        .DIn   (DIn),
        .DOut  (DOut),
        .IRQ   (IRQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIn  = d;
        We   = 1'b1;
        step();
        We   = 1'b0;
    endtask

    task automatic rd_exp(input logic [1:0] a, input string tag, input logic [31:0] v);
        push_exp(tag, v);
        Addr = a;
        #1;
        pop_cmp(DOut);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        We    = 1'b0;
        Addr  = 2'd0;
        DIn   = 32'd0;
        step();
        reset = 1'b0;

        // Reset readback
        push_exp("rst_irq", 32'd0);
        pop_cmp({31'd0, IRQ});
        rd_exp(2'd0, "rst_ctrl", 32'd0);
        rd_exp(2'd1, "rst_preset", 32'd7);
        rd_exp(2'd2, "rst_count", 32'd0);
        step();
        rd_exp(2'd3, "rst_rsvd", 32'd0);

        // One-shot: PRESET=5, IRQ rises 7 edges after the CTRL write
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 9; k++) push_exp($sformatf("oneshot_irq_k%0d", k), (k >= 7) ? 32'd1 : 32'd0);
        for (int k = 1; k <= 9; k++) begin
            step();
            pop_cmp({31'd0, IRQ});
        end
        rd_exp(2'd0, "oneshot_ctrl_en_cleared", 32'h8);
        rd_exp(2'd2, "oneshot_count_zero", 32'd0);
        bus_write(2'd0, 32'h8);
        push_exp("oneshot_ack_irq", 32'd0);
        pop_cmp({31'd0, IRQ});

        // Async reset with IRQ high
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 3; k++) push_exp($sformatf("pre_rst_irq_k%0d", k), (k >= 3) ? 32'd1 : 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            pop_cmp({31'd0, IRQ});
        end
        #2;
        reset = 1'b1;
        #1;
        push_exp("async_rst_irq", 32'd0);
        pop_cmp({31'd0, IRQ});
        rd_exp(2'd0, "async_rst_ctrl", 32'd0);
        rd_exp(2'd1, "async_rst_preset", 32'd7);
        rd_exp(2'd2, "async_rst_count", 32'd0);
        step();
        reset = 1'b0;

        // Auto-reload: PRESET=3, pulses every 5 cycles, COUNT 3,2,1,0
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'hB);
        Addr = 2'd2;
        for (int k = 1; k <= 22; k++) begin
            int ph;
            logic [31:0] c;
            ph = (k - 2) % 5;
            if (k == 1)       c = 32'd0;
            else if (ph == 0) c = 32'd3;
            else if (ph == 1) c = 32'd2;
            else if (ph == 2) c = 32'd1;
            else              c = 32'd0;
            push_exp($sformatf("reload_irq_k%0d", k), (k >= 5 && (k - 5) % 5 == 0) ? 32'd1 : 32'd0);
            push_exp($sformatf("reload_count_k%0d", k), c);
        end
        for (int k = 1; k <= 22; k++) begin
            step();
            pop_cmp({31'd0, IRQ});
            pop_cmp(DOut);
        end
        pulse_reset();

        // Mask: IM=0 hides the expiry, CTRL write acknowledges it
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) push_exp($sformatf("mask_irq_k%0d", k), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            pop_cmp({31'd0, IRQ});
        end
        bus_write(2'd0, 32'h8);
        for (int k = 0; k < 3; k++) push_exp($sformatf("mask_ack_irq_%0d", k), 32'd0);
        for (int k = 0; k < 3; k++) begin
            pop_cmp({31'd0, IRQ});
            step();
        end

        // Pause at COUNT=6, then PRESET=0 behaves as 1
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);
        Addr = 2'd2;
        for (int k = 2; k <= 5; k++) push_exp($sformatf("pause_count_k%0d", k), 32'(12 - k));
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k >= 2) pop_cmp(DOut);
        end
        bus_write(2'd0, 32'h8);
        Addr = 2'd2;
        for (int k = 0; k < 4; k++) begin
            push_exp($sformatf("pause_hold_count_%0d", k), 32'd6);
            push_exp($sformatf("pause_hold_irq_%0d", k), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            pop_cmp(DOut);
            pop_cmp({31'd0, IRQ});
            step();
        end
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 4; k++) push_exp($sformatf("preset0_irq_k%0d", k), (k >= 3) ? 32'd1 : 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            pop_cmp({31'd0, IRQ});
        end
        bus_write(2'd2, 32'h55);
        rd_exp(2'd2, "count_write_ignored", 32'd0);
        push_exp("count_write_no_ack", 32'd1);
        pop_cmp({31'd0, IRQ});

        // Prescaled one-shot (PSC field only exists with the prescaler)
        bus_write(2'd1, 32'd4);
        bus_write(2'd0, 32'h39);
`ifdef TIMER_PRESCALE_EN
        rd_exp(2'd0, "psc_ctrl_readback", 32'h39);
        for (int k = 1; k <= 19; k++) push_exp($sformatf("psc_irq_k%0d", k), (k >= 18) ? 32'd1 : 32'd0);
        for (int k = 1; k <= 19; k++) begin
            step();
            pop_cmp({31'd0, IRQ});
        end
`else
        rd_exp(2'd0, "psc_ctrl_readback", 32'h9);
        for (int k = 1; k <= 7; k++) push_exp($sformatf("psc_irq_k%0d", k), (k >= 6) ? 32'd1 : 32'd0);
        for (int k = 1; k <= 7; k++) begin
            step();
            pop_cmp({31'd0, IRQ});
        end
`endif

        if (exp_q.size() != 0) check("scoreboard_leftover", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
